// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the cache-side memory arbiter.
package mem_arb_pkg;

  localparam int DEF_NUM_REQ = 3;    // inst, data, prefetch
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_LINE_W  = 256;

  // Arbiter phases: wait for a requester, talk to the adaptor, pulse resp.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first pending port at or after rr_ptr,
// wrapping modulo NUM_REQ. rr_ptr is assumed to be below NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest pending port wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (pending[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ cache ports onto one cacheline
// adaptor. Handshake: a port holds req_read/req_write (with addr/wdata) until
// it sees its one-cycle resp pulse; the adaptor sees mem_read/mem_write held
// until it answers with a one-cycle mem_resp. One transaction in flight.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_read,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][LINE_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]               resp,
  output logic [LINE_W-1:0]                rdata,
  output logic                             mem_read,
  output logic                             mem_write,
  output logic [ADDR_W-1:0]                mem_address,
  output logic [LINE_W-1:0]                mem_wdata,
  input  logic [LINE_W-1:0]                mem_rdata,
  input  logic                             mem_resp,
  output logic                             busy,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output state_t                           dbg_state_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     grant_id_q;
  logic [NUM_REQ-1:0]   resp_q;
  logic                 mem_read_q;
  logic                 mem_write_q;
  logic [ADDR_W-1:0]    mem_address_q;
  logic [LINE_W-1:0]    mem_wdata_q;
  logic [LINE_W-1:0]    rdata_q;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .pending (req_read | req_write),
    .rr_ptr  (rr_ptr_q),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

  // Arbiter FSM; mem_read_q/mem_write_q double as the latched operation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      resp_q        <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
    end else begin
      resp_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_id_q    <= pick_idx;
            mem_address_q <= req_addr[pick_idx];
            mem_wdata_q   <= req_wdata[pick_idx];
            // Write wins when a port raises both.
            if (req_write[pick_idx]) begin
              mem_write_q <= 1'b1;
            end else begin
              mem_read_q  <= 1'b1;
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_resp) begin
            if (mem_read_q) begin
              rdata_q <= mem_rdata;
            end
            mem_read_q         <= 1'b0;
            mem_write_q        <= 1'b0;
            resp_q[grant_id_q] <= 1'b1;
            state_q            <= DONE;
          end
        end
        DONE: begin
          if (grant_id_q == IDX_W'(NUM_REQ - 1)) begin
            rr_ptr_q <= '0;
          end else begin
            rr_ptr_q <= grant_id_q + 1'b1;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign resp        = resp_q;
  assign rdata       = rdata_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule
